// File: rtl/gray_counter.sv
// Up/down 4-bit Gray-code counter with a valid/ready output handshake,
// a synchronous Gray-coded load and a registered wrap pulse.
module gray_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       o_ready,
  output logic [3:0] g,
  output logic       o_valid,
  output logic       wrap
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e     state_q, state_d;
  logic [3:0] b_q, b_d;
  logic [3:0] g_q, g_d;
  logic       wrap_q, wrap_d;
  logic       fire;

  function automatic logic [3:0] gray2bin(input logic [3:0] gv);
    logic [3:0] bv;
    bv[3] = gv[3];
    for (int k = 2; k >= 0; k--) begin
      bv[k] = bv[k+1] ^ gv[k];
    end
    return bv;
  endfunction

  assign fire = (state_q == StActive) && o_ready;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    wrap_d  = 1'b0;
    if (ld) begin
      // Load wins over enable and fire; any stalled word is dropped.
      b_d     = gray2bin(ld_val);
      state_d = StActive;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) state_d = StActive;
        end
        StActive: begin
          if (fire) begin
            if (en) begin
              b_d    = up ? b_q + 4'd1 : b_q - 4'd1;
              wrap_d = up ? (b_q == 4'd15) : (b_q == 4'd0);
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    g_d = b_d ^ (b_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      b_q     <= 4'd0;
      g_q     <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      g_q     <= g_d;
      wrap_q  <= wrap_d;
    end
  end

  assign g       = g_q;
  assign o_valid = (state_q == StActive);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter with hand-computed expectations.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] ld_val;
  logic       o_ready;
  logic [3:0] g;
  logic       o_valid;
  logic       wrap;

  int n_checks = 0;
  int n_fails  = 0;

  logic [3:0] seq_exp [17];

  gray_counter u_dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .up     (up),
    .ld     (ld),
    .ld_val (ld_val),
    .o_ready(o_ready),
    .g      (g),
    .o_valid(o_valid),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic ev,
                           input logic ew);
    check_eq({tag, ".g"}, {4'd0, g}, {4'd0, eg});
    check_eq({tag, ".valid"}, {7'd0, o_valid}, {7'd0, ev});
    check_eq({tag, ".wrap"}, {7'd0, wrap}, {7'd0, ew});
  endtask

  initial begin
    seq_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                4'b0000};
    rst = 1'b1; en = 1'b1; up = 1'b1; ld = 1'b0; ld_val = 4'd0; o_ready = 1'b1;
    step();
    check_out("reset", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Full up-count: first edge only activates, then 16 steps back to 0.
    for (int i = 0; i < 17; i++) begin
      step();
      check_out($sformatf("up%0d", i), seq_exp[i], 1'b1, (i == 16));
    end

    // Down from 0 wraps to 15, then 14; then reverse direction to 15.
    up = 1'b0;
    step(); check_out("dn_wrap", 4'b1000, 1'b1, 1'b1);
    step(); check_out("dn14", 4'b1001, 1'b1, 1'b0);
    up = 1'b1;
    step(); check_out("dirchg", 4'b1000, 1'b1, 1'b0);

    // Fire with en low returns to idle, then idle holds.
    en = 1'b0;
    step(); check_out("to_idle", 4'b1000, 1'b0, 1'b0);
    step(); check_out("idle_hold", 4'b1000, 1'b0, 1'b0);

    // Load and enable together in idle: load wins, no step.
    ld = 1'b1; en = 1'b1; ld_val = 4'b0011;
    step(); check_out("ld_idle", 4'b0011, 1'b1, 1'b0);
    ld = 1'b0;

    // Backpressure while en/up toggle.
    o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = i[0]; up = ~i[0];
      step(); check_out($sformatf("stall%0d", i), 4'b0011, 1'b1, 1'b0);
    end
    o_ready = 1'b1; en = 1'b1; up = 1'b1;
    step(); check_out("unstall", 4'b0010, 1'b1, 1'b0);

    // Load over a stalled word.
    o_ready = 1'b0;
    step(); check_out("stall_b", 4'b0010, 1'b1, 1'b0);
    ld = 1'b1; ld_val = 4'b1101;
    step(); check_out("ld_stall", 4'b1101, 1'b1, 1'b0);
    ld = 1'b0; o_ready = 1'b1;
    step(); check_out("ld_step", 4'b1111, 1'b1, 1'b0);

    // Load with fire and en high: no step; then load 15 and wrap upward.
    ld = 1'b1; ld_val = 4'b1000;
    step(); check_out("ld_15", 4'b1000, 1'b1, 1'b0);
    ld = 1'b0;
    step(); check_out("ld_wrap", 4'b0000, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle while ACTIVE with g=0110.
    ld = 1'b1; ld_val = 4'b0110;
    step(); check_out("ld_0110", 4'b0110, 1'b1, 1'b0);
    ld = 1'b0;
    #2 rst = 1'b1;
    #1 check_out("async_rst", 4'b0000, 1'b0, 1'b0);
    step(); check_out("rst_hold", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b0;
    step(); check_out("post_rst_idle", 4'b0000, 1'b0, 1'b0);
    en = 1'b1;
    step(); check_out("post_rst_act", 4'b0000, 1'b1, 1'b0);
    step(); check_out("post_rst_step", 4'b0001, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  asynchronous, active-high reset; acts immediately, independent of clk.
REQ-004 Port en  input  1  count enable; requests that the sequence start or continue.
REQ-005 Port up  input  1  direction: 1 = increment, 0 = decrement, sampled at each step.
REQ-006 Port ld  input  1  synchronous load strobe.
REQ-007 Port ld_val  input  4  Gray-coded load value.
REQ-008 Port o_ready  input  1  downstream (Gray-to-binary stage) accepts g this cycle.
REQ-009 Port g  output  4  registered Gray-code count word.
REQ-010 Port o_valid  output  1  g holds a word not yet accepted.
REQ-011 Port wrap  output  1  one-cycle pulse; the step just taken crossed the 15/0 boundary.

Function
REQ-012 The block SHALL keep an internal 4-bit binary count b and SHALL register g = b XOR (b >> 1), so g always equals the Gray code of b.
REQ-013 The FSM SHALL have exactly two states: IDLE (o_valid=0) and ACTIVE (o_valid=1).
REQ-014 fire SHALL be defined as o_valid AND o_ready.
REQ-015 IDLE, en=1, ld=0: the FSM SHALL go to ACTIVE next cycle, with o_valid=1 and g = Gray(b) unchanged (no step).
REQ-016 IDLE, en=0, ld=0: the FSM SHALL hold all state.
REQ-017 ACTIVE, fire, en=1: b SHALL step +1 (up=1) or -1 (up=0) modulo 16; the new g SHALL appear next cycle; o_valid SHALL stay 1.
REQ-018 ACTIVE, fire, en=0: the FSM SHALL return to IDLE next cycle with o_valid=0 and b, g held.
REQ-019 ACTIVE, no fire: g, b and o_valid SHALL hold stable regardless of en and up (backpressure).
REQ-020 ld=1 in either state SHALL take priority over en and fire.
REQ-021 On ld=1, b SHALL load Gray-to-binary(ld_val): b[3]=ld_val[3], b[k]=b[k+1] XOR ld_val[k].
REQ-022 On ld=1, g SHALL equal ld_val next cycle, o_valid SHALL be 1, and the FSM SHALL enter ACTIVE.
REQ-023 An unaccepted word pending when ld=1 arrives SHALL be discarded without being presented.
REQ-024 wrap SHALL be 1 in the cycle after a step from b=15 to 0 (up=1) or from b=0 to 15 (up=0).
REQ-025 wrap SHALL be 0 at all other times, including after loads, stalls and direction changes.
REQ-026 Successive presented g words SHALL differ in exactly one bit, except across a load.
REQ-027 The combinational path from inputs to outputs SHALL be empty; all outputs SHALL be registered.

Reset
REQ-028 While rst=1: b=0, g=4'b0000, o_valid=0, wrap=0, and the FSM SHALL be in IDLE.
REQ-029 rst asserted mid-operation, including during a stall or a load cycle, SHALL discard the pending word and force the reset values asynchronously.
REQ-030 After rst deasserts, the first clk edge SHALL be handled per REQ-015/016/020.

Verification
REQ-031 Reset release, en=1, up=1, o_ready=1 for 17 cycles -> g sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 exactly once, with the final 0000.
REQ-032 up=0 from b=0 with o_ready=1 -> g goes 0000 then 1000; wrap=1 on the 1000 cycle.
REQ-033 ACTIVE with g=0011, o_ready=0 for 5 cycles while en and up toggle -> g=0011 and o_valid=1 stable throughout; after o_ready=1, next g=0010 if up=1 at the fire.
REQ-034 ld=1, ld_val=4'b1101 while a word is stalled -> next cycle g=1101, o_valid=1; after one fire with up=1, g=1111 (b 9->10).
REQ-035 ld=1 and en=1 together in IDLE -> ld wins: g=ld_val, ACTIVE, no step that cycle.
REQ-036 rst pulsed between clk edges while ACTIVE with g=0110 -> g=0000, o_valid=0 and wrap=0 immediately, before the next clk edge.
